reg_alias_file: RTL and testbench

- Rename/dispatch-side architectural register file with alias table; sits directly upstream of the 16-entry ROB.
- Accepts up to 4 decoded instructions per cycle and allocates ROB slots head+0..3 in slot order, forwarding valid/target pairs to the ROB.
- Resolves each instruction's two source operands to either a committed value or a pending ROB tag.
- Consumes the ROB's 4-wide register-write (commit) port to update architectural state and clear pending tags.

---
 rtl/reg_alias_file.sv | 135 +++++++++++++
 tb/tb_reg_alias_file.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alias_file.sv
// rtl/reg_alias_file.sv - rename-stage register file with alias table feeding a 16-entry ROB
// Resolves source operands to committed values or pending ROB tags and absorbs the ROB commit port.
module reg_alias_file #(
  parameter int NREGS     = 16,
  parameter int DW        = 16,
  parameter int ROB_DEPTH = 16,
  localparam int RW       = $clog2(NREGS),
  localparam int TW       = $clog2(ROB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid    [4],
  input  logic          in_has_dest [4],
  input  logic [RW-1:0] in_dest     [4],
  input  logic [RW-1:0] in_src_a    [4],
  input  logic [RW-1:0] in_src_b    [4],
  output logic          dispatch_ready,
  input  logic [TW-1:0] rob_head,
  input  logic [TW-1:0] rob_size,
  output logic          rob_valid   [4],
  output logic [RW-1:0] rob_targets [4],
  output logic          src_a_busy  [4],
  output logic          src_b_busy  [4],
  output logic [TW-1:0] src_a_tag   [4],
  output logic [TW-1:0] src_b_tag   [4],
  output logic [DW-1:0] src_a_val   [4],
  output logic [DW-1:0] src_b_val   [4],
  input  logic          commit_we   [4],
  input  logic [RW-1:0] commit_reg  [4],
  input  logic [DW-1:0] commit_data [4],
  input  logic [TW-1:0] commit_tag  [4]
);

  typedef struct packed {
    logic          busy;
    logic [TW-1:0] tag;
    logic [DW-1:0] val;
  } opnd_t;

  logic [NREGS-1:0][DW-1:0] regs_q;
  logic [NREGS-1:0]         busy_q;
  logic [NREGS-1:0][TW-1:0] tag_q;

  logic [2:0]    n_valid;
  logic [TW:0]   occupancy;
  logic          fire  [4];
  logic [TW-1:0] alloc [4];

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < 4; i++) begin
      n_valid = n_valid + {2'b00, in_valid[i]};
    end
    occupancy      = {1'b0, rob_size} + (TW+1)'(n_valid);
    dispatch_ready = (occupancy <= (TW+1)'(ROB_DEPTH - 1));
    for (int i = 0; i < 4; i++) begin
      fire[i]        = in_valid[i] & dispatch_ready;
      alloc[i]       = rob_head + TW'(i);
      rob_valid[i]   = fire[i];
      rob_targets[i] = in_has_dest[i] ? in_dest[i] : '0;
    end
  end

  // Younger in-group writers shadow the table; a same-cycle commit of the current tag is bypassed.
  function automatic opnd_t resolve(input int j, input logic [RW-1:0] s);
    opnd_t r;
    logic  hit;
    r   = '0;
    hit = 1'b0;
    if (s != '0) begin
      for (int i = 0; i < j; i++) begin
        if (fire[i] && in_has_dest[i] && in_dest[i] == s) begin
          hit    = 1'b1;
          r.busy = 1'b1;
          r.tag  = alloc[i];
        end
      end
      if (!hit) begin
        if (busy_q[s]) begin
          r.busy = 1'b1;
          r.tag  = tag_q[s];
          for (int k = 0; k < 4; k++) begin
            if (commit_we[k] && commit_reg[k] == s && commit_tag[k] == tag_q[s]) begin
              r.busy = 1'b0;
              r.tag  = '0;
              r.val  = commit_data[k];
            end
          end
        end else begin
          r.val = regs_q[s];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    opnd_t ra;
    opnd_t rb;
    for (int j = 0; j < 4; j++) begin
      ra            = resolve(j, in_src_a[j]);
      rb            = resolve(j, in_src_b[j]);
      src_a_busy[j] = ra.busy;
      src_a_tag[j]  = ra.tag;
      src_a_val[j]  = ra.val;
      src_b_busy[j] = rb.busy;
      src_b_tag[j]  = rb.tag;
      src_b_val[j]  = rb.val;
    end
  end

  // Later loop iterations override earlier ones, so highest commit lane and highest slot win,
  // and any rename beats a commit clear on the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (commit_we[k] && commit_reg[k] != '0) begin
          regs_q[commit_reg[k]] <= commit_data[k];
          busy_q[commit_reg[k]] <= busy_q[commit_reg[k]] & (tag_q[commit_reg[k]] != commit_tag[k]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && in_has_dest[i] && in_dest[i] != '0) begin
          busy_q[in_dest[i]] <= 1'b1;
          tag_q[in_dest[i]]  <= alloc[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_alias_file.sv
// tb/tb_reg_alias_file.sv - scoreboard bench for reg_alias_file
module tb_reg_alias_file;

  logic        clk;
  logic        rst_n;
  logic        in_valid    [4];
  logic        in_has_dest [4];
  logic [3:0]  in_dest     [4];
  logic [3:0]  in_src_a    [4];
  logic [3:0]  in_src_b    [4];
  logic        dispatch_ready;
  logic [3:0]  rob_head;
  logic [3:0]  rob_size;
  logic        rob_valid   [4];
  logic [3:0]  rob_targets [4];
  logic        src_a_busy  [4];
  logic        src_b_busy  [4];
  logic [3:0]  src_a_tag   [4];
  logic [3:0]  src_b_tag   [4];
  logic [15:0] src_a_val   [4];
  logic [15:0] src_b_val   [4];
  logic        commit_we   [4];
  logic [3:0]  commit_reg  [4];
  logic [15:0] commit_data [4];
  logic [3:0]  commit_tag  [4];

  reg_alias_file dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_has_dest(in_has_dest), .in_dest(in_dest),
    .in_src_a(in_src_a), .in_src_b(in_src_b),
    .dispatch_ready(dispatch_ready), .rob_head(rob_head), .rob_size(rob_size),
    .rob_valid(rob_valid), .rob_targets(rob_targets),
    .src_a_busy(src_a_busy), .src_b_busy(src_b_busy),
    .src_a_tag(src_a_tag), .src_b_tag(src_b_tag),
    .src_a_val(src_a_val), .src_b_val(src_b_val),
    .commit_we(commit_we), .commit_reg(commit_reg),
    .commit_data(commit_data), .commit_tag(commit_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_RDY, K_RV, K_RT, K_AB, K_AT, K_AV, K_BB, K_BT, K_BV} kind_e;
  typedef struct {
    kind_e       kind;
    int          slot;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  vectors;
  int  miscompares;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k, input int s);
    case (k)
      K_RDY:   return 32'(dispatch_ready);
      K_RV:    return 32'(rob_valid[s]);
      K_RT:    return 32'(rob_targets[s]);
      K_AB:    return 32'(src_a_busy[s]);
      K_AT:    return 32'(src_a_tag[s]);
      K_AV:    return 32'(src_a_val[s]);
      K_BB:    return 32'(src_b_busy[s]);
      K_BT:    return 32'(src_b_tag[s]);
      K_BV:    return 32'(src_b_val[s]);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input kind_e k, input int s, input logic [31:0] v);
    sb_t e;
    e.kind = k;
    e.slot = s;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic exp_a(input int s, input logic bz, input logic [3:0] t, input logic [15:0] v);
    push(K_AB, s, 32'(bz));
    push(K_AT, s, 32'(t));
    push(K_AV, s, 32'(v));
  endtask

  task automatic exp_b(input int s, input logic bz, input logic [3:0] t, input logic [15:0] v);
    push(K_BB, s, 32'(bz));
    push(K_BT, s, 32'(t));
    push(K_BV, s, 32'(v));
  endtask

  task automatic exp_group(input logic rdy, input logic [3:0] rv);
    push(K_RDY, 0, 32'(rdy));
    for (int i = 0; i < 4; i++) push(K_RV, i, 32'(rv[i]));
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; in_has_dest[i] = 1'b0; in_dest[i] = '0;
      in_src_a[i] = '0;   in_src_b[i] = '0;
      commit_we[i] = 1'b0; commit_reg[i] = '0; commit_data[i] = '0; commit_tag[i] = '0;
    end
    rob_head = '0;
    rob_size = '0;
  endtask

  task automatic slot(input int i, input logic hd, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
    in_valid[i] = 1'b1; in_has_dest[i] = hd; in_dest[i] = d;
    in_src_a[i] = a;    in_src_b[i] = b;
  endtask

  task automatic cmt(input int k, input logic [3:0] r, input logic [3:0] t, input logic [15:0] d);
    commit_we[k] = 1'b1; commit_reg[k] = r; commit_tag[k] = t; commit_data[k] = d;
  endtask

  task automatic begin_vec();
    @(negedge clk);
    idle();
  endtask

  task automatic end_vec();
    sb_t e;
    #2;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_eq($sformatf("%s[%0d]", e.kind.name(), e.slot), observe(e.kind, e.slot), e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    idle();
    // reset state
    begin_vec(); slot(0, 0, 0, 5, 0);
    exp_group(1, 4'b0001); exp_a(0, 0, 0, 0); end_vec();
    rst_n = 1'b1;

    // commit to a non-busy register writes data
    begin_vec(); slot(0, 0, 0, 5, 0); cmt(0, 5, 3, 16'h1234);
    exp_a(0, 0, 0, 0); exp_b(0, 0, 0, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 5, 0);
    exp_a(0, 0, 0, 16'h1234); end_vec();

    // in-group rename bypass
    begin_vec(); rob_head = 2; slot(0, 1, 3, 1, 2); slot(1, 0, 0, 3, 0);
    exp_group(1, 4'b0011); push(K_RT, 0, 3); push(K_RT, 1, 0);
    exp_a(0, 0, 0, 0); exp_a(1, 1, 2, 0); end_vec();
    begin_vec(); rob_head = 4; slot(0, 0, 0, 3, 5);
    exp_a(0, 1, 2, 0); exp_b(0, 0, 0, 16'h1234); end_vec();

    // commit bypass on matching tag
    begin_vec(); rob_head = 5; slot(0, 0, 0, 3, 0); cmt(0, 3, 2, 16'hBEEF);
    exp_a(0, 0, 0, 16'hBEEF); end_vec();
    begin_vec(); slot(0, 0, 0, 3, 0);
    exp_a(0, 0, 0, 16'hBEEF); end_vec();

    // stale commit leaves younger writer pending
    begin_vec(); rob_head = 2; slot(0, 1, 3, 0, 0); push(K_RT, 0, 3); end_vec();
    begin_vec(); rob_head = 5; slot(0, 1, 3, 0, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 3, 0); cmt(0, 3, 2, 16'h00AA);
    exp_a(0, 1, 5, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 3, 0);
    exp_a(0, 1, 5, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 3, 0); cmt(2, 3, 5, 16'h0777);
    exp_a(0, 0, 0, 16'h0777); end_vec();

    // dispatch_ready boundary
    begin_vec(); rob_size = 13;
    slot(0, 1, 7, 0, 0); slot(1, 0, 0, 7, 0); slot(2, 0, 0, 0, 0); slot(3, 0, 0, 0, 0);
    exp_group(0, 4'b0000); push(K_RT, 0, 7); exp_a(1, 0, 0, 0); end_vec();
    begin_vec(); rob_size = 12;
    slot(0, 1, 7, 0, 0); slot(1, 0, 0, 0, 0); slot(2, 0, 0, 0, 0); slot(3, 0, 0, 0, 0);
    exp_group(0, 4'b0000); end_vec();
    begin_vec(); rob_size = 11; rob_head = 14;
    slot(0, 1, 8, 1, 2); slot(1, 1, 9, 8, 5); slot(2, 1, 10, 3, 9); slot(3, 1, 11, 8, 10);
    exp_group(1, 4'b1111);
    push(K_RT, 0, 8); push(K_RT, 1, 9); push(K_RT, 2, 10); push(K_RT, 3, 11);
    exp_a(0, 0, 0, 0); exp_a(1, 1, 14, 0); exp_b(1, 0, 0, 16'h1234);
    exp_a(2, 0, 0, 16'h0777); exp_b(2, 1, 15, 0); exp_a(3, 1, 14, 0); exp_b(3, 1, 0, 0);
    end_vec();
    begin_vec(); slot(0, 0, 0, 7, 11); slot(1, 0, 0, 10, 9);
    exp_a(0, 0, 0, 0); exp_b(0, 1, 1, 0); exp_a(1, 1, 0, 0); exp_b(1, 1, 15, 0); end_vec();

    // same dest in two slots
    begin_vec(); rob_head = 3; slot(0, 1, 12, 0, 0); slot(1, 1, 12, 0, 0); slot(2, 0, 0, 12, 0);
    exp_a(2, 1, 4, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 12, 0); exp_a(0, 1, 4, 0); end_vec();

    // rename overrides same-cycle commit clear
    begin_vec(); rob_head = 6; slot(0, 1, 7, 0, 0); end_vec();
    begin_vec(); rob_head = 9; slot(0, 1, 7, 7, 0); slot(1, 0, 0, 7, 0); cmt(1, 7, 6, 16'h7777);
    exp_a(0, 0, 0, 16'h7777); exp_a(1, 1, 9, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 7, 0); exp_a(0, 1, 9, 0); end_vec();

    // register 0 never renamed or written
    begin_vec(); slot(0, 1, 0, 0, 0); slot(1, 0, 0, 0, 0); cmt(0, 0, 0, 16'hFFFF);
    push(K_RT, 0, 0); exp_a(1, 0, 0, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 0, 0); exp_a(0, 0, 0, 0); end_vec();

    // multiple commits to one register: highest lane decides data and busy
    begin_vec(); slot(0, 0, 0, 11, 0); cmt(0, 11, 1, 16'h1111); cmt(2, 11, 7, 16'h2222);
    exp_a(0, 0, 0, 16'h1111); end_vec();
    begin_vec(); slot(0, 0, 0, 11, 0); exp_a(0, 1, 1, 0); end_vec();
    begin_vec(); slot(0, 0, 0, 11, 0); cmt(3, 11, 1, 16'hABCD);
    exp_a(0, 0, 0, 16'hABCD); end_vec();
    begin_vec(); slot(0, 0, 0, 11, 0); exp_a(0, 0, 0, 16'hABCD); end_vec();

    // asynchronous reset mid-group
    begin_vec(); slot(0, 0, 0, 12, 10); slot(1, 0, 0, 3, 0);
    rst_n = 1'b0;
    exp_a(0, 0, 0, 0); exp_b(0, 0, 0, 0); exp_a(1, 0, 0, 0); end_vec();
    rst_n = 1'b1;
    begin_vec(); slot(0, 0, 0, 12, 3); exp_a(0, 0, 0, 0); exp_b(0, 0, 0, 0); end_vec();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
